mmio_port: RTL and testbench

Memory-mapped I/O responder on the processor's RAM bus. It decodes a 16-word window at the top of the 12-bit address space and serves switch input, the 7-segment output value, a prescaled timer with compare, and sticky status flags. Read data returns one cycle after the address, matching the synchronous RAM, so the top level can mux `io_q` against the RAM's `q` using `io_sel`.

---
 rtl/mmio_port.sv | 147 ++++++++++++++
 tb/tb_mmio_port.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mmio_port.sv
// rtl/mmio_port.sv - memory-mapped I/O responder: switches, display value, prescaled timer with compare, sticky flags
module mmio_port #(
    parameter logic [7:0]  BASE     = 8'hFF,
    parameter logic [15:0] PRESCALE = 16'd1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] m_addr,
    input  logic [15:0] m_data,
    input  logic        m_rw,
    input  logic [15:0] inp,
    output logic [15:0] io_q,
    output logic        io_sel,
    output logic [15:0] outval
);

    localparam logic [3:0] OFF_SW     = 4'd0;
    localparam logic [3:0] OFF_OUT    = 4'd1;
    localparam logic [3:0] OFF_TIMER  = 4'd2;
    localparam logic [3:0] OFF_CMP    = 4'd3;
    localparam logic [3:0] OFF_STATUS = 4'd4;

    // A terminal count of 0 keeps the prescaler parked and ticks every cycle.
    localparam logic [15:0] PRE_LAST = (PRESCALE <= 16'd1) ? 16'd0 : PRESCALE - 16'd1;

    logic        hit;
    logic [3:0]  off;
    logic        wr_out;
    logic        wr_timer;
    logic        wr_cmp;
    logic        wr_status;

    logic [15:0] sw_meta;
    logic [15:0] sw_sync;
    logic [15:0] sw_prev;
    logic        swchg_set;

    logic [15:0] pre_cnt;
    logic        tick;

    logic [15:0] out_reg;
    logic [15:0] timer;
    logic [15:0] timer_d;
    logic [15:0] cmp_reg;
    logic [15:0] cmp_d;
    logic        match_set;
    logic        flag_match;
    logic        flag_swchg;
    logic [15:0] rd_mux;

    assign hit       = (m_addr[11:4] == BASE);
    assign off       = m_addr[3:0];
    assign wr_out    = hit && m_rw && (off == OFF_OUT);
    assign wr_timer  = hit && m_rw && (off == OFF_TIMER);
    assign wr_cmp    = hit && m_rw && (off == OFF_CMP);
    assign wr_status = hit && m_rw && (off == OFF_STATUS);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sw_meta <= 16'd0;
            sw_sync <= 16'd0;
            sw_prev <= 16'd0;
        end else begin
            sw_meta <= inp;
            sw_sync <= sw_meta;
            sw_prev <= sw_sync;
        end
    end

    assign swchg_set = (sw_sync != sw_prev);

    assign tick = (pre_cnt == PRE_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pre_cnt <= 16'd0;
        end else if (tick) begin
            pre_cnt <= 16'd0;
        end else begin
            pre_cnt <= pre_cnt + 16'd1;
        end
    end

    // A software TIMER write overrides the tick increment in the same cycle.
    always_comb begin
        timer_d = timer;
        if (wr_timer) begin
            timer_d = m_data;
        end else if (tick) begin
            timer_d = timer + 16'd1;
        end
    end

    always_comb begin
        cmp_d = cmp_reg;
        if (wr_cmp) begin
            cmp_d = m_data;
        end
    end

    // Only an increment that lands on CMP raises MATCH, never a direct write.
    assign match_set = tick && !wr_timer && (timer_d == cmp_d);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_reg    <= 16'd0;
            timer      <= 16'd0;
            cmp_reg    <= 16'd0;
            flag_match <= 1'b0;
            flag_swchg <= 1'b0;
        end else begin
            if (wr_out) begin
                out_reg <= m_data;
            end
            timer      <= timer_d;
            cmp_reg    <= cmp_d;
            flag_match <= match_set || (flag_match && !(wr_status && m_data[0]));
            flag_swchg <= swchg_set || (flag_swchg && !(wr_status && m_data[1]));
        end
    end

    always_comb begin
        rd_mux = 16'd0;
        case (off)
            OFF_SW:     rd_mux = sw_sync;
            OFF_OUT:    rd_mux = out_reg;
            OFF_TIMER:  rd_mux = timer;
            OFF_CMP:    rd_mux = cmp_reg;
            OFF_STATUS: rd_mux = {14'd0, flag_swchg, flag_match};
            default:    rd_mux = 16'd0;
        endcase
    end

    // Read data is captured from pre-write contents so it lines up with the RAM's q.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            io_q   <= 16'd0;
            io_sel <= 1'b0;
        end else begin
            io_sel <= hit;
            io_q   <= (hit && !m_rw) ? rd_mux : 16'd0;
        end
    end

    assign outval = out_reg;

endmodule

// File: tb/tb_mmio_port.sv
// tb/tb_mmio_port.sv - scoreboard bench for mmio_port with PRESCALE=4 and PRESCALE=1 instances
module tb_mmio_port;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] m_addr = 12'd0;
    logic [15:0] m_data = 16'd0;
    logic        m_rw = 1'b0;
    logic [15:0] inp = 16'd0;

    logic [15:0] io_q0, io_q1, outval0, outval1;
    logic        io_sel0, io_sel1;

    mmio_port #(.BASE(8'hFF), .PRESCALE(16'd4)) dut (
        .clock(clock), .reset(reset), .m_addr(m_addr), .m_data(m_data), .m_rw(m_rw),
        .inp(inp), .io_q(io_q0), .io_sel(io_sel0), .outval(outval0)
    );

    mmio_port #(.BASE(8'hFF), .PRESCALE(16'd1)) dut1 (
        .clock(clock), .reset(reset), .m_addr(m_addr), .m_data(m_data), .m_rw(m_rw),
        .inp(inp), .io_q(io_q1), .io_sel(io_sel1), .outval(outval1)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       tag;
        int          due;
        int          which;
        logic        sel;
        logic [15:0] q;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   edge_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic bus_drive(input logic [11:0] a, input logic [15:0] d, input logic rw);
        @(negedge clock);
        m_addr = a;
        m_data = d;
        m_rw   = rw;
    endtask

    task automatic push_exp(input string tag, input int which, input logic sel, input logic [15:0] q);
        exp_t e;
        e.tag   = tag;
        e.due   = edge_cnt + 1;
        e.which = which;
        e.sel   = sel;
        e.q     = q;
        sb.push_back(e);
    endtask

    // which: 0 = PRESCALE 4 instance, 1 = PRESCALE 1 instance, 2 = both
    task automatic read_exp(input logic [11:0] a, input string tag, input int which,
                            input logic sel, input logic [15:0] q);
        bus_drive(a, 16'd0, 1'b0);
        push_exp(tag, which, sel, q);
    endtask

    task automatic bus_idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus_drive(12'h000, 16'd0, 1'b0);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            edge_cnt++;
            #1;
            while (sb.size() > 0 && sb[0].due <= edge_cnt) begin
                e = sb.pop_front();
                if (e.which != 1) begin
                    check_eq({e.tag, ".sel0"}, {31'd0, io_sel0}, {31'd0, e.sel});
                    check_eq({e.tag, ".q0"}, {16'd0, io_q0}, {16'd0, e.q});
                end
                if (e.which != 0) begin
                    check_eq({e.tag, ".sel1"}, {31'd0, io_sel1}, {31'd0, e.sel});
                    check_eq({e.tag, ".q1"}, {16'd0, io_q1}, {16'd0, e.q});
                end
            end
        end
    end

    initial begin : stim
        repeat (2) @(negedge clock);
        check_eq("rst.q0", {16'd0, io_q0}, 32'd0);
        check_eq("rst.sel0", {31'd0, io_sel0}, 32'd0);
        check_eq("rst.outval0", {16'd0, outval0}, 32'd0);
        check_eq("rst.q1", {16'd0, io_q1}, 32'd0);
        check_eq("rst.sel1", {31'd0, io_sel1}, 32'd0);
        check_eq("rst.outval1", {16'd0, outval1}, 32'd0);
        reset = 1'b1;

        bus_drive(12'hFF1, 16'hBEEF, 1'b1);
        push_exp("wr_out", 2, 1'b1, 16'h0000);
        bus_idle(1);
        check_eq("outval0", {16'd0, outval0}, 32'h0000BEEF);
        check_eq("outval1", {16'd0, outval1}, 32'h0000BEEF);
        read_exp(12'hFF1, "rd_out", 2, 1'b1, 16'hBEEF);
        read_exp(12'hFE1, "rd_outside", 2, 1'b0, 16'h0000);
        read_exp(12'hFF7, "rd_unused", 2, 1'b1, 16'h0000);

        // Exactly three prescaled ticks fall in the 12 edges after the TIMER write.
        bus_drive(12'hFF2, 16'h0000, 1'b1);
        bus_drive(12'hFF3, 16'h0003, 1'b1);
        bus_idle(11);
        read_exp(12'hFF2, "timer_at_cmp", 0, 1'b1, 16'h0003);
        read_exp(12'hFF4, "match_set", 0, 1'b1, 16'h0001);
        bus_drive(12'hFF4, 16'h0001, 1'b1);
        read_exp(12'hFF4, "match_w1c", 0, 1'b1, 16'h0000);

        bus_drive(12'hFF2, 16'hFFFF, 1'b1);
        read_exp(12'hFF2, "timer_ffff", 1, 1'b1, 16'hFFFF);
        read_exp(12'hFF2, "timer_wrap", 1, 1'b1, 16'h0000);
        bus_drive(12'hFF2, 16'h0010, 1'b1);
        read_exp(12'hFF2, "timer_wr_prio", 1, 1'b1, 16'h0010);

        @(negedge clock);
        inp = 16'h0005;
        m_addr = 12'h000;
        m_rw = 1'b0;
        bus_idle(2);
        read_exp(12'hFF0, "sw_5", 2, 1'b1, 16'h0005);
        read_exp(12'hFF4, "swchg_set", 0, 1'b1, 16'h0002);

        @(negedge clock);
        inp = 16'h0007;
        m_addr = 12'h000;
        m_rw = 1'b0;
        bus_idle(1);
        bus_drive(12'hFF4, 16'h0002, 1'b1);
        read_exp(12'hFF4, "swchg_set_wins", 0, 1'b1, 16'h0002);
        bus_drive(12'hFF4, 16'h0002, 1'b1);
        read_exp(12'hFF4, "swchg_w1c", 0, 1'b1, 16'h0000);
        read_exp(12'hFF0, "sw_7", 2, 1'b1, 16'h0007);

        bus_drive(12'hFF2, 16'h1234, 1'b1);
        read_exp(12'hFF2, "timer_1234", 2, 1'b1, 16'h1234);
        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        check_eq("arst.q0", {16'd0, io_q0}, 32'd0);
        check_eq("arst.sel0", {31'd0, io_sel0}, 32'd0);
        check_eq("arst.outval0", {16'd0, outval0}, 32'd0);
        check_eq("arst.q1", {16'd0, io_q1}, 32'd0);
        check_eq("arst.sel1", {31'd0, io_sel1}, 32'd0);
        check_eq("arst.outval1", {16'd0, outval1}, 32'd0);
        m_addr = 12'h000;
        m_rw = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        read_exp(12'hFF2, "timer_after_rst", 0, 1'b1, 16'h0000);
        read_exp(12'hFF1, "out_after_rst", 2, 1'b1, 16'h0000);
        bus_idle(3);

        check_eq("sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
